// File: rtl/scan_pkg.sv
// Shared types, widths and the IDLE-exit slot picker for the display scan sequencer.
// Define SCAN_REVERSE_EN to scan slots in descending order (7 -> 0).
package scan_pkg;

    localparam int SEL_W     = 3;
    localparam int NUM_SLOTS = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BLANK  = 2'd1,
        ACTIVE = 2'd2
    } scan_state_t;

    // First slot of a fresh frame: lowest set bit, or highest in the reversed build.
    function automatic logic [SEL_W-1:0] first_set(input logic [NUM_SLOTS-1:0] mask);
        logic [SEL_W-1:0] idx;
        idx = '0;
`ifdef SCAN_REVERSE_EN
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (mask[i]) idx = SEL_W'(i);
        end
`else
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (mask[i]) idx = SEL_W'(i);
        end
`endif
        return idx;
    endfunction

endpackage

// File: rtl/scan_sequencer_next_slot_finder.sv
// Combinational rotated priority encoder: finds the next enabled slot after cur.
// Honours SCAN_REVERSE_EN (descending scan order when defined).
module next_slot_finder
    import scan_pkg::*;
(
    input  logic [SEL_W-1:0]     cur,
    input  logic [NUM_SLOTS-1:0] mask,
    output logic [SEL_W-1:0]     next,
    output logic                 wrapped,
    output logic                 none
);

    // rot[k] is the mask bit k+1 steps away from cur in scan order; step 8 lands on cur itself.
    logic [NUM_SLOTS-1:0] rot;
    logic [SEL_W-1:0]     off;
    logic                 found;
    logic [SEL_W:0]       target;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_rot
`ifdef SCAN_REVERSE_EN
            assign rot[gi] = mask[cur - SEL_W'(gi + 1)];
`else
            assign rot[gi] = mask[cur + SEL_W'(gi + 1)];
`endif
        end
    endgenerate

    always_comb begin
        off   = '0;
        found = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off   = SEL_W'(i);
                found = 1'b1;
            end
        end
    end

    // The extra MSB of target flags that the step crossed the 7/0 seam.
`ifdef SCAN_REVERSE_EN
    assign target = {1'b0, cur} - {1'b0, off} - (SEL_W + 1)'(1);
`else
    assign target = {1'b0, cur} + {1'b0, off} + (SEL_W + 1)'(1);
`endif

    assign next    = target[SEL_W-1:0];
    assign wrapped = found & target[SEL_W];
    assign none    = ~found;

endmodule

// File: rtl/scan_sequencer.sv
// Time-multiplexed scan controller driving a 3-to-8 decoder with blanking between slots.
// Define SCAN_REVERSE_EN to scan slots in descending order; ports are identical in both builds.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int PRESCALE    = 4,
    parameter int DEAD_CYCLES = 1,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [NUM_SLOTS-1:0] slot_mask,
    output logic [SEL_W-1:0]     sel,
    output logic                 sel_valid,
    output logic                 slot_start,
    output logic                 frame_done
);

    localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(PRESCALE - 1);
    localparam scan_state_t      SLOT_ENTRY  = (DEAD_CYCLES == 0) ? ACTIVE : BLANK;
    localparam logic             ENTRY_VALID = (DEAD_CYCLES == 0);

    scan_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  plan_sel_q, plan_sel_d;
    logic              plan_stop_q, plan_stop_d;
    logic              sel_valid_q, sel_valid_d;
    logic              slot_start_q, slot_start_d;
    logic              frame_done_q, frame_done_d;

    logic [CNT_W-1:0]  cnt_inc;
    logic              inc_blank;
    logic [SEL_W-1:0]  fnd_next;
    logic              fnd_wrapped;
    logic              fnd_none;

    next_slot_finder u_finder (
        .cur     (sel_q),
        .mask    (slot_mask),
        .next    (fnd_next),
        .wrapped (fnd_wrapped),
        .none    (fnd_none)
    );

    assign cnt_inc = cnt_q + CNT_W'(1);

    generate
        if (DEAD_CYCLES == 0) begin : g_no_dead
            assign inc_blank = 1'b0;
        end else begin : g_dead
            localparam logic [CNT_W-1:0] DEAD_CNT = CNT_W'(DEAD_CYCLES);
            assign inc_blank = (cnt_inc < DEAD_CNT);
        end
    endgenerate

    // The slot-change decision is taken on the edge entering a slot's last cycle, so the
    // registered frame_done lines up with that last cycle; the plan is applied one edge later.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        plan_sel_d   = plan_sel_q;
        plan_stop_d  = plan_stop_q;
        sel_valid_d  = 1'b0;
        slot_start_d = 1'b0;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (en && (slot_mask != '0)) begin
                    state_d      = SLOT_ENTRY;
                    cnt_d        = '0;
                    sel_d        = first_set(slot_mask);
                    sel_valid_d  = ENTRY_VALID;
                    slot_start_d = 1'b1;
                end
            end
            default: begin
                if (!en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (plan_stop_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d      = SLOT_ENTRY;
                        sel_d        = plan_sel_q;
                        sel_valid_d  = ENTRY_VALID;
                        slot_start_d = 1'b1;
                    end
                end else begin
                    cnt_d       = cnt_inc;
                    state_d     = inc_blank ? BLANK : ACTIVE;
                    sel_valid_d = ~inc_blank;
                    if (cnt_inc == LAST_CNT) begin
                        plan_sel_d   = fnd_next;
                        plan_stop_d  = fnd_none;
                        frame_done_d = fnd_wrapped;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sel_q        <= '0;
            plan_sel_q   <= '0;
            plan_stop_q  <= 1'b0;
            sel_valid_q  <= 1'b0;
            slot_start_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            plan_sel_q   <= plan_sel_d;
            plan_stop_q  <= plan_stop_d;
            sel_valid_q  <= sel_valid_d;
            slot_start_q <= slot_start_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign sel        = sel_q;
    assign sel_valid  = sel_valid_q;
    assign slot_start = slot_start_q;
    assign frame_done = frame_done_q;

endmodule
